// File: rtl/sw_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg -- shared constants and types for the slide-switch input stage.
//
// Contents:
//   SW_WIDTH                 number of board slide switches
//   SW_TICK_DIV_DEFAULT      clocks per debounce sample tick (1 ms at 100 MHz)
//   SW_STABLE_TICKS_DEFAULT  consecutive differing samples before a flip
//   sw_vec_t                 one bit per switch
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int SW_WIDTH                = 16;
  localparam int SW_TICK_DIV_DEFAULT     = 100000;
  localparam int SW_STABLE_TICKS_DEFAULT = 10;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage : sw_pkg

// File: rtl/sw_debounce_tick_gen.sv
// -----------------------------------------------------------------------------
// sw_tick_gen -- free-running prescaler producing a one-clock sample strobe.
//
// The counter runs 0..TICK_DIV-1 and wraps. tick is a decode of the terminal
// count, so it is high for exactly one clock per period and the first strobe
// lands TICK_DIV clock edges after reset release (on the edge that consumes
// it). Kept generic so display-multiplex stages can reuse it.
//
// Parameters:
//   TICK_DIV  clocks per tick, must be >= 2
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   tick  out  one-clock strobe when the count is TICK_DIV-1
// -----------------------------------------------------------------------------
module sw_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count is 0 while reset is held, so the strobe is low during reset.
  assign tick = (cnt_q == CNT_LAST);

endmodule : sw_tick_gen

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce -- conditions the raw slide switches before the LED stage.
//
// Each raw bit passes through a two-flop synchroniser. A shared prescaler
// strobe samples the synchronised levels; each bit keeps a small counter of
// consecutive samples that disagree with its debounced level. After
// STABLE_TICKS disagreeing samples in a row the debounced bit flips and a
// one-clock rise or fall pulse is registered on the same edge. Any sample that
// agrees with the current level restarts the count, which rejects short
// glitches.
//
// Build option:
//   SW_DEBOUNCE_BYPASS_EN  when defined, the prescaler and counters are not
//                          built, tick is held at 0, and sw_db follows the
//                          synchroniser every clock (3-cycle latency). Edge
//                          pulses still fire once per change.
//
// Parameters:
//   WIDTH         number of switch channels
//   TICK_DIV      clocks per sample tick (>= 2)
//   STABLE_TICKS  consecutive differing samples needed to flip (>= 1)
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   sw_raw   in   raw, asynchronous, bouncing switch levels
//   sw_db    out  debounced levels (drives the LED stage sw input)
//   sw_rise  out  one-clock pulse per bit when sw_db goes 0->1
//   sw_fall  out  one-clock pulse per bit when sw_db goes 1->0
//   tick     out  one-clock sample strobe
// -----------------------------------------------------------------------------
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = SW_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = SW_STABLE_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);

  // ---------------------------------------------------------------------------
  // Synchroniser: the only flops that look at sw_raw.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounced level and edge pulse registers.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sw_db_q;
  logic [WIDTH-1:0] sw_db_d;
  logic [WIDTH-1:0] sw_rise_q;
  logic [WIDTH-1:0] sw_rise_d;
  logic [WIDTH-1:0] sw_fall_q;
  logic [WIDTH-1:0] sw_fall_d;

`ifdef SW_DEBOUNCE_BYPASS_EN

  // Bring-up path: no filtering, follow the synchroniser directly.
  assign tick = 1'b0;

  always_comb begin
    sw_db_d   = sync2_q;
    // Compare the outgoing level with the incoming one so a pulse is
    // registered on the same edge that sw_db changes.
    sw_rise_d = sync2_q & ~sw_db_q;
    sw_fall_d = ~sync2_q & sw_db_q;
  end

`else

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic             tick_w;
  logic [WIDTH-1:0] flip_vec;

  sw_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_w)
  );

  assign tick = tick_w;

  // Per-bit stability counters. The counter only moves on tick cycles and
  // always returns to 0 when it flips the output, so it never saturates.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip;

    always_comb begin
      cnt_d = cnt_q;
      flip  = 1'b0;
      if (tick_w) begin
        if (sync2_q[gi] == sw_db_q[gi]) begin
          // Sample agrees with the current level: any run is broken.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          // This is the STABLE_TICKS-th differing sample in a row.
          cnt_d = '0;
          flip  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign flip_vec[gi] = flip;
  end : g_bit

  always_comb begin
    // A flipping bit takes the sampled level, which is by construction the
    // opposite of its current level, so the direction follows from sync2_q.
    sw_db_d   = (sw_db_q & ~flip_vec) | (sync2_q & flip_vec);
    sw_rise_d = flip_vec & sync2_q;
    sw_fall_d = flip_vec & ~sync2_q;
  end

`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_db_q   <= '0;
      sw_rise_q <= '0;
      sw_fall_q <= '0;
    end else begin
      sw_db_q   <= sw_db_d;
      sw_rise_q <= sw_rise_d;
      sw_fall_q <= sw_fall_d;
    end
  end

  assign sw_db   = sw_db_q;
  assign sw_rise = sw_rise_q;
  assign sw_fall = sw_fall_q;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce -- directed self-checking bench for sw_debounce with
// TICK_DIV=4 and STABLE_TICKS=3. Edges after reset release are numbered from 1;
// outputs are sampled 1 ns after each rising edge and inputs change there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sw_debounce;
    import sw_pkg::*;

    localparam int TDIV = 4;
    localparam int STB  = 3;

    logic    clk;
    logic    rst;
    sw_vec_t sw_raw;
    sw_vec_t sw_db;
    sw_vec_t sw_rise;
    sw_vec_t sw_fall;
    logic    tick;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    sw_debounce #(
        .WIDTH        (SW_WIDTH),
        .TICK_DIV     (TDIV),
        .STABLE_TICKS (STB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n++;
        n_cmp++;
        if ((sw_rise & sw_fall) !== 16'h0000) fail("rise_fall_excl", sw_rise & sw_fall, 16'h0000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int      first;
        int      found;
        int      rise_cnt;
        sw_vec_t acc_a;
        sw_vec_t acc_b;
        sw_vec_t acc_c;
        logic    exp_tick;
        sw_vec_t exp_vec;

        rst    = 1'b1;
        sw_raw = '0;
        cyc();
        cyc();
        n_cmp++; if (sw_db   !== 16'h0000) fail("reset_db",   sw_db,   16'h0000);
        n_cmp++; if (sw_rise !== 16'h0000) fail("reset_rise", sw_rise, 16'h0000);
        n_cmp++; if (sw_fall !== 16'h0000) fail("reset_fall", sw_fall, 16'h0000);
        n_cmp++; if (tick    !== 1'b0)     fail("reset_tick", tick,    1'b0);
        rst = 1'b0;
        n   = 0;

`ifdef SW_DEBOUNCE_BYPASS_EN
        sw_raw[7] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_cmp++; if (tick !== 1'b0) fail("byp_tick", tick, 1'b0);
            if (k < 3) begin
                n_cmp++; if (sw_db !== 16'h0000) fail("byp_db_pre", sw_db, 16'h0000);
            end else begin
                n_cmp++; if (sw_db !== 16'h0080) fail("byp_db_post", sw_db, 16'h0080);
            end
            exp_vec = (k == 3) ? 16'h0080 : 16'h0000;
            n_cmp++; if (sw_rise !== exp_vec) fail("byp_rise", sw_rise, exp_vec);
            n_cmp++; if (sw_fall !== 16'h0000) fail("byp_fall", sw_fall, 16'h0000);
        end
`else
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_tick = ((n % TDIV) == TDIV - 1);
            n_cmp++; if (tick !== exp_tick) fail("tick_phase", tick, exp_tick);
            n_cmp++; if (sw_db !== 16'h0000) fail("idle_db", sw_db, 16'h0000);
        end

        sw_raw[0] = 1'b1;
        first     = 0;
        rise_cnt  = 0;
        acc_a     = '0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            rise_cnt += int'(sw_rise[0]);
            acc_a    |= sw_fall;
            if (sw_db[0] && first == 0) begin
                first = k;
                n_cmp++; if (sw_rise !== 16'h0001) fail("step_rise_at_change", sw_rise, 16'h0001);
            end else if (first != 0 && k == first + 1) begin
                n_cmp++; if (sw_rise !== 16'h0000) fail("step_rise_cleared", sw_rise, 16'h0000);
            end
        end
        n_cmp++; if (first !== 12) fail("step_latency", first, 12);
        n_cmp++; if ((first >= 11 && first <= 15) !== 1'b1) fail("step_latency_window", first, 11);
        n_cmp++; if (rise_cnt !== 1) fail("step_rise_count", rise_cnt, 1);
        n_cmp++; if (acc_a !== 16'h0000) fail("step_no_fall", acc_a, 16'h0000);
        n_cmp++; if (sw_db !== 16'h0001) fail("step_db", sw_db, 16'h0001);

        sw_raw[3] = 1'b1;
        acc_a = '0;
        acc_b = '0;
        acc_c = '0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 6) sw_raw[3] = 1'b0;
            acc_a |= sw_db;
            acc_b |= sw_rise;
            acc_c |= sw_fall;
        end
        n_cmp++; if (acc_a[3] !== 1'b0) fail("glitch_db3", acc_a[3], 1'b0);
        n_cmp++; if (acc_b !== 16'h0000) fail("glitch_rise", acc_b, 16'h0000);
        n_cmp++; if (acc_c !== 16'h0000) fail("glitch_fall", acc_c, 16'h0000);
        n_cmp++; if (sw_db !== 16'h0001) fail("glitch_db", sw_db, 16'h0001);

        sw_raw = '0;
        found  = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            cyc();
            if (!sw_db[0]) begin
                found = 1;
                n_cmp++; if (sw_fall !== 16'h0001) fail("release_fall", sw_fall, 16'h0001);
                n_cmp++; if (sw_rise !== 16'h0000) fail("release_rise", sw_rise, 16'h0000);
            end
        end
        n_cmp++; if (found !== 1) fail("release_seen", found, 1);
        cyc();
        n_cmp++; if (sw_fall !== 16'h0000) fail("release_fall_cleared", sw_fall, 16'h0000);

        sw_raw = 16'hFFFF;
        found  = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            cyc();
            if (sw_db != 16'h0000) begin
                found = 1;
                n_cmp++; if (sw_db   !== 16'hFFFF) fail("all_db",   sw_db,   16'hFFFF);
                n_cmp++; if (sw_rise !== 16'hFFFF) fail("all_rise", sw_rise, 16'hFFFF);
                n_cmp++; if (sw_fall !== 16'h0000) fail("all_fall", sw_fall, 16'h0000);
            end
        end
        n_cmp++; if (found !== 1) fail("all_seen", found, 1);
        cyc();
        n_cmp++; if (sw_rise !== 16'h0000) fail("all_rise_cleared", sw_rise, 16'h0000);

        sw_raw = 16'hFFDF;
        for (int k = 1; k <= 6; k++) cyc();
        n_cmp++; if (sw_db   !== 16'hFFFF) fail("pre_rst_db",   sw_db,   16'hFFFF);
        n_cmp++; if (sw_fall !== 16'h0000) fail("pre_rst_fall", sw_fall, 16'h0000);
        rst = 1'b1;
        #1;
        n_cmp++; if (sw_db   !== 16'h0000) fail("async_rst_db",   sw_db,   16'h0000);
        n_cmp++; if (sw_rise !== 16'h0000) fail("async_rst_rise", sw_rise, 16'h0000);
        n_cmp++; if (sw_fall !== 16'h0000) fail("async_rst_fall", sw_fall, 16'h0000);
        n_cmp++; if (tick    !== 1'b0)     fail("async_rst_tick", tick,    1'b0);
        cyc();
        rst = 1'b0;
        n   = 0;
        acc_c = '0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            acc_c |= sw_fall;
            if (k == 11) begin
                n_cmp++; if (sw_db !== 16'h0000) fail("post_rst_db_hold", sw_db, 16'h0000);
            end
            if (k == 12) begin
                n_cmp++; if (sw_db   !== 16'hFFDF) fail("post_rst_db",   sw_db,   16'hFFDF);
                n_cmp++; if (sw_rise !== 16'hFFDF) fail("post_rst_rise", sw_rise, 16'hFFDF);
            end
        end
        n_cmp++; if (acc_c !== 16'h0000) fail("post_rst_no_fall", acc_c, 16'h0000);
        n_cmp++; if (sw_db !== 16'hFFDF) fail("post_rst_final",   sw_db, 16'hFFDF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sw_debounce
